// File: rtl/z_demux_pkg.sv
// Shared constants for the 1-to-2 demultiplexer: channel select encoding and
// default sizing.
package z_demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/z_demux_fifo.sv
// Small synchronous FIFO with an occupancy counter. The head word is read
// straight from the storage array, so it holds its last value while empty.
module z_demux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Guard here too so a misbehaving parent can never overrun or underrun.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/z_1_2_demux.sv
// Sequential 1-to-2 demultiplexer: steers a tagged input stream into two
// buffered output channels and counts the words delivered on each.
module z_1_2_demux
    import z_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b, pop_a, pop_b;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

    // Ready depends only on the select and registered full flags, never on
    // the consumer readies, so no combinational path crosses the block.
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;

    assign push_a = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b = in_valid && in_ready && (in_sel == SEL_B);

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;
    assign pop_a   = a_valid && a_ready;
    assign pop_b   = b_valid && b_ready;

    z_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_a),
        .data_i  (in_data),
        .pop_i   (pop_a),
        .data_o  (a_data),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    z_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_b),
        .data_i  (in_data),
        .pop_i   (pop_b),
        .data_o  (b_data),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (pop_a) a_cnt_d = a_cnt_q + CNT_W'(1);
        if (pop_b) b_cnt_d = b_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;

endmodule

// File: tb/tb_z_1_2_demux.sv
// Bench for z_1_2_demux: directed scenarios plus random traffic, all checked
// against a queue-based model of the two channels.
module tb_z_1_2_demux;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel, in_valid, in_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_valid, b_valid, a_ready, b_ready;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    int               cnt_a, cnt_b;

    z_1_2_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    // One clock cycle: drive, compare every output with the model, then
    // advance the model by what the protocol says happens at the edge.
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
        logic exp_ready, acc, pa, pb;
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_ready = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
        chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) chk("a_data", 32'(a_data), 32'(qa[0]));
        if (qb.size() != 0) chk("b_data", 32'(b_data), 32'(qb[0]));
        chk("a_cnt", 32'(a_cnt), 32'(cnt_a));
        chk("b_cnt", 32'(b_cnt), 32'(cnt_b));
        acc = v && exp_ready;
        pa  = (qa.size() != 0) && ar;
        pb  = (qb.size() != 0) && br;
        @(posedge clk);
        if (pa) begin
            void'(qa.pop_front());
            cnt_a = (cnt_a + 1) % (1 << CNT_W);
        end
        if (pb) begin
            void'(qb.pop_front());
            cnt_b = (cnt_b + 1) % (1 << CNT_W);
        end
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        model_reset();
        #12;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic steering to both channels.
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("basic_a_cnt", 32'(a_cnt), 32'd1);
        chk("basic_b_cnt", 32'(b_cnt), 32'd1);

        // Stalled channel B fills, A still flows, full push refused during pop.
        do_reset();
        step(1'b1, 1'b1, 8'h30, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h32, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("stall_b_cnt", 32'(b_cnt), 32'd3);

        // Counter wrap: 257 deliveries on A.
        do_reset();
        for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_a_cnt", 32'(a_cnt), 32'd1);
        chk("wrap_b_cnt", 32'(b_cnt), 32'd0);

        // Random traffic with varying consumer readiness.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset with both channels full.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 8'(8'hA0 + i), 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_a_valid", 32'(a_valid), 32'd0);
        chk("async_b_valid", 32'(b_valid), 32'd0);
        chk("async_a_cnt", 32'(a_cnt), 32'd0);
        chk("async_b_cnt", 32'(b_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
